// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter driving a 3-to-8 decoder's select/enable,
// with a registered one-hot grant and a per-grant hold-time limit.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt,
    output logic       timeout
);

    // Handshake: req is a level held by each requester; the holder of the grant
    // ends it with a one-cycle done (sampled only in GRANT) or by dropping req.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        sel_q, sel_d;
    logic              en_q, en_d;
    logic [7:0]        gnt_q, gnt_d;
    logic              timeout_q, timeout_d;

    logic [2:0] win;
    logic [2:0] idx;
    logic       found;

    // First requester at or after ptr, scanning upward with wrap-around.
    always_comb begin
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        sel_d     = sel_q;
        en_d      = en_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d   = win;
                    en_d    = 1'b1;
                    gnt_d   = 8'h01 << win;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hold_d = hold_q + 1'b1;
                if (done || !req[sel_q] || (hold_q == HOLD_LAST)) begin
                    // done wins over the hold limit, so timeout only on a pure forced release
                    timeout_d = !done && req[sel_q];
                    en_d      = 1'b0;
                    gnt_d     = 8'h00;
                    ptr_d     = sel_q + 3'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 3'd0;
            hold_q    <= '0;
            sel_q     <= 3'd0;
            en_q      <= 1'b0;
            gnt_q     <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign gnt     = gnt_q;
    assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that owns the 3-to-8 decoder's select and enable. It picks one requester at a time and drives the 3-bit index plus enable into the decoder. It also provides a registered one-hot grant, so requesters are sequenced onto the shared decoded-select resource. A hold-time limit stops any single requester from monopolising the resource.

## Interface
Parameters:
- `MAX_HOLD`, 15: maximum number of consecutive cycles one grant may stay asserted. Legal range 1..2^HOLD_W.
- `HOLD_W`, 4: width of the hold counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 8: level request, one bit per requester.
- `done`, in, 1: the current grant holder releases the resource. Sampled only in GRANT.
- `sel`, out, 3: index of the granted requester (decoder select).
- `en`, out, 1: grant valid (decoder enable).
- `gnt`, out, 8: registered one-hot grant, equal to the decode of `sel` when `en`=1, else 8'h00.
- `timeout`, out, 1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- FSM states are IDLE and GRANT. The encoding is free.
- Round-robin pointer `ptr`, 3 bits:
  - Holds the highest-priority index.
  - Reset value 0.
  - After each release, `ptr` = released index + 1, modulo 8 (7 wraps to 0).
- **IDLE:**
  - If `req` != 0, pick the first set bit scanning `ptr`, `ptr`+1, … `ptr`+7 (mod 8).
  - Load `sel`, set `en`=1 and `gnt` to the one-hot of the winner, clear the hold counter, and go to GRANT.
  - If `req` == 0, stay in IDLE.
- **GRANT:** the hold counter increments each cycle. The grant ends at the edge where any of the following holds, in priority order:
  1. `done`=1: normal release, no timeout.
  2. `req[sel]`=0: the requester withdrew; no timeout.
  3. hold counter == `MAX_HOLD`-1: forced release, `timeout`=1 for the following cycle.
- **On release:**
  - `en`=0 and `gnt`=0.
  - `sel` keeps its last value; it is don't-care while `en`=0.
  - `ptr` updates and the FSM returns to IDLE.
  - The new arbitration uses the updated `ptr`.
- **Simultaneous events:**
  - `done` together with the hold limit counts as a normal release, so no `timeout`.
  - Requests arriving during GRANT are ignored until the next IDLE cycle.
- **Reset values (asynchronous, any state):** state=IDLE, `ptr`=0, hold counter=0, `sel`=3'd0, `en`=0, `gnt`=8'h00, `timeout`=0.
  - A reset during GRANT drops `en` and `gnt` immediately, without waiting for a clock edge.
- Every output comes straight from a register, with no combinational path from `req` or `done` to any output.
- Invariant: `gnt` always has at most one bit set, and `gnt` != 0 if and only if `en`=1.

## Timing
- Request to grant: with `req` sampled nonzero at edge N while in IDLE, `en`/`sel`/`gnt` are valid after edge N, so latency is 1 cycle.
- Grant duration: with `done` sampled at edge M, `en` falls after edge M. The grant therefore covers the cycles from N+1 through M.
- Maximum grant: `en` is high for exactly `MAX_HOLD` cycles. `timeout` is high for the single cycle after the forced release.
- Back-to-back grants: there is always exactly one `en`=0 cycle (the IDLE cycle) between consecutive grants.
- Worst-case wait for a continuously requesting port with all 8 requesting: 7×(`MAX_HOLD`+1) cycles.

## Test plan
1. Reset, then idle: assert `rst_n`=0 for 3 cycles with `req`=8'hFF. Require `en`=0, `gnt`=8'h00, `sel`=0 and `timeout`=0 throughout.
2. Single request:
   - `req`=8'h10 at edge N gives `sel`=4, `en`=1 and `gnt`=8'h10 after edge N.
   - Pulsing `done` at N+3 drops `en` after N+3.
   - `ptr` becomes 5, so the next grant with `req`=8'h30 goes to index 5.
3. Fairness and wrap: hold `req`=8'hFF and pulse `done` on every grant's first cycle. Grants must follow the order 0,1,2,…,7,0,1, each separated by one idle cycle.
4. Hold limit (`MAX_HOLD`=15): `req`=8'h01 held, `done`=0. Require `en` high for exactly 15 cycles, then `timeout`=1 for one cycle.
   - With `req`=8'h03 still set, the next grant goes to index 1.
5. Priority collisions:
   - `done`=1 on the 15th grant cycle gives release with `timeout`=0.
   - `req[sel]` dropping mid-grant (for example `req` 8'h84→8'h80 while `sel`=2) releases the grant. Index 7 is granted two cycles later.
6. Reset mid-grant: with `en`=1 and `sel`=6, asserting `rst_n`=0 between clock edges clears `en` and `gnt` asynchronously. After release, `req`=8'hC0 grants index 6, because `ptr` is back at 0.
